// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // Number of bits needed to hold values 0 .. v-1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step on unsigned magnitudes.
module div_step #(
  parameter int unsigned TAM = 4
) (
  input  logic [TAM:0]   i_rem,
  input  logic           i_bit,
  input  logic [TAM-1:0] i_dvs,
  output logic [TAM:0]   o_rem,
  output logic           o_qbit
);

  logic [TAM+1:0] w_shift;
  logic [TAM+1:0] w_diff;

  // A clear sign bit on the trial difference means the divisor fits.
  always_comb begin
    w_shift = {i_rem, i_bit};
    w_diff  = w_shift - {2'b00, i_dvs};
    o_qbit  = ~w_diff[TAM+1];
    o_rem   = o_qbit ? w_diff[TAM:0] : w_shift[TAM:0];
  end

endmodule

// File: rtl/booth_divider.sv
// Sequential signed divider with start/busy/done handshake; results follow
// Verilog '/' and '%' (truncate toward zero, remainder takes dividend sign).
module booth_divider
  import div_pkg::*;
#(
  parameter int unsigned TAM = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [TAM-1:0] A,
  input  logic [TAM-1:0] B,
  output logic [TAM-1:0] Q,
  output logic [TAM-1:0] R,
  output logic           busy,
  output logic           done,
  output logic           div_zero,
  output logic           ovf
);

  localparam int unsigned CW = clog2(TAM + 1);

  state_t         r_state;
  state_t         w_state_nx;
  logic [CW-1:0]  r_cnt;
  logic [TAM:0]   r_rem;
  logic [TAM-1:0] r_dq;
  logic [TAM-1:0] r_dvs;
  logic           r_sa;
  logic           r_sb;
  logic           r_zero;
  logic           r_ovf_p;

  logic           w_accept;
  logic           w_b_zero;
  logic [TAM-1:0] w_abs_a;
  logic [TAM-1:0] w_abs_b;
  logic [TAM:0]   w_rem_nx;
  logic           w_qbit;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_b_zero = (B == '0);
  // |most-negative| wraps to 2^(TAM-1), which is the correct unsigned magnitude.
  assign w_abs_a  = A[TAM-1] ? -A : A;
  assign w_abs_b  = B[TAM-1] ? -B : B;

  div_step #(.TAM(TAM)) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_dq[TAM-1]),
    .i_dvs  (r_dvs),
    .o_rem  (w_rem_nx),
    .o_qbit (w_qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nx = w_b_zero ? S_FIX : S_CALC;
      S_CALC:  if (r_cnt == CW'(TAM - 1)) w_state_nx = S_FIX;
      S_FIX:   w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Operand capture, iteration and sign fix-up of the registered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_dq     <= '0;
      r_dvs    <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf_p  <= 1'b0;
      Q        <= '0;
      R        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      done <= (r_state == S_FIX);
      if (w_accept)  busy <= 1'b1;
      else if (done) busy <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sa    <= A[TAM-1];
            r_sb    <= B[TAM-1];
            r_dq    <= w_abs_a;
            r_dvs   <= w_abs_b;
            r_cnt   <= '0;
            // Zero divisor skips iteration; seeding |A| makes the sign fix yield R = A.
            r_rem   <= w_b_zero ? {1'b0, w_abs_a} : '0;
            r_zero  <= w_b_zero;
            r_ovf_p <= (A == {1'b1, {(TAM-1){1'b0}}}) && (&B);
          end
        end
        S_CALC: begin
          r_rem <= w_rem_nx;
          r_dq  <= {r_dq[TAM-2:0], w_qbit};
          r_cnt <= r_cnt + CW'(1);
        end
        S_FIX: begin
          Q        <= r_zero ? '1 : ((r_sa ^ r_sb) ? -r_dq : r_dq);
          R        <= r_sa ? -r_rem[TAM-1:0] : r_rem[TAM-1:0];
          div_zero <= r_zero;
          ovf      <= r_ovf_p;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_divider.sv
// Randomised and directed bench for booth_divider against a latency/arithmetic model.
module tb_booth_divider;

  localparam int unsigned TAM = 4;

  logic           clk;
  logic           rst;
  logic           start;
  logic [TAM-1:0] A;
  logic [TAM-1:0] B;
  logic [TAM-1:0] Q;
  logic [TAM-1:0] R;
  logic           busy;
  logic           done;
  logic           div_zero;
  logic           ovf;

  int chk_cnt;
  int err_cnt;
  int cyc;

  // Model state: results packed as {Q, R, div_zero, ovf}.
  logic [9:0] m_out;
  logic [9:0] m_pend;
  logic       m_busy;
  logic       m_done;
  int         m_left;

  booth_divider #(.TAM(TAM)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .A        (A),
    .B        (B),
    .Q        (Q),
    .R        (R),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .ovf      (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  function automatic logic [9:0] ref_div(input logic [3:0] a, input logic [3:0] b);
    int ia;
    int ib;
    ia = int'($signed(a));
    ib = int'($signed(b));
    if (b == 4'h0)                      return {4'hF, a, 2'b10};
    else if (a == 4'h8 && b == 4'hF)    return {4'h8, 4'h0, 2'b01};
    else                                return {4'(ia / ib), 4'(ia % ib), 2'b00};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Latency model: result appears TAM+1 edges after acceptance (1 edge for B == 0).
  always @(posedge clk) begin
    if (rst) begin
      m_left = 0;
      m_out  = '0;
      m_pend = '0;
      m_busy = 1'b0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left != 0) begin
        m_left--;
        if (m_left == 0) begin
          m_out  = m_pend;
          m_done = 1'b1;
        end
      end else if (start) begin
        m_pend = ref_div(A, B);
        m_left = (B == 4'h0) ? 1 : TAM + 1;
      end
      m_busy = (m_left != 0) || m_done;
    end
  end

  always @(negedge clk) begin
    check("cycle_outputs", 32'({busy, done, Q, R, div_zero, ovf}),
          32'({m_busy, m_done, m_out}));
  end

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!done && lat < 30);
    check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic run_op(input string name, input logic [3:0] a, input logic [3:0] b,
                        input logic [9:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat);
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check(name, 32'({Q, R, div_zero, ovf}), 32'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int prev;
    logic [3:0] ra;
    logic [3:0] rb;
    chk_cnt = 0;
    err_cnt = 0;
    cyc     = 0;
    rst     = 1'b1;
    start   = 1'b0;
    A       = '0;
    B       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({Q, R, busy, done, div_zero, ovf}), 32'd0);
    rst = 1'b0;

    run_op("pos_pos",  4'd7,    4'd2,    {4'd3,    4'd1,    2'b00}, 5);
    run_op("neg_pos",  4'b1001, 4'd2,    {4'b1101, 4'b1111, 2'b00}, 5);
    run_op("pos_neg",  4'd7,    4'b1110, {4'b1101, 4'd1,    2'b00}, 5);
    run_op("div_zero", 4'd7,    4'd0,    {4'hF,    4'd7,    2'b10}, 1);
    run_op("overflow", 4'b1000, 4'hF,    {4'b1000, 4'd0,    2'b01}, 5);
    run_op("min_by_1", 4'b1000, 4'd1,    {4'b1000, 4'd0,    2'b00}, 5);

    // Start pulsed mid-calculation must be ignored.
    @(negedge clk);
    A = 4'd7; B = 4'd2; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    A = 4'd5; B = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check("ignore_start_lat", 32'(lat), 32'd4);
    check("ignore_start", 32'({Q, R, div_zero, ovf}), 32'({4'd3, 4'd1, 2'b00}));

    // Reset in the middle of a calculation aborts it.
    @(negedge clk);
    A = 4'd7; B = 4'd2; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 check("abort_outputs", 32'({Q, R, busy, done, div_zero, ovf}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 check("abort_no_done", 32'(done), 32'd0);
    end

    // Back-to-back random operations.
    do begin
      ra = 4'($urandom);
      rb = 4'($urandom);
    end while (rb == 4'h0 || (ra == 4'h8 && rb == 4'hF));
    @(negedge clk);
    A = ra; B = rb; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    prev = -1;
    for (int i = 0; i < 200; i++) begin
      wait_done(lat);
      if (prev >= 0) check("spacing", 32'(cyc - prev), 32'(TAM + 2));
      prev = cyc;
      if (i < 199) begin
        do begin
          ra = 4'($urandom);
          rb = 4'($urandom);
        end while (rb == 4'h0 || (ra == 4'h8 && rb == 4'hF));
        A = ra; B = rb; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/booth_divider.md
# booth_divider

Sequential signed integer divider, the inverse companion of the `booth4` combinational multiplier. It takes a TAM-bit signed dividend `A` and divisor `B` and produces quotient `Q` and remainder `R` with the same semantics as Verilog `/` and `%`: truncation toward zero, and the remainder takes the dividend's sign. It uses a start/busy/done handshake and a radix-2 restoring algorithm on magnitudes. It sits beside the multiplier in the arithmetic datapath and is verified by a bench of the same style (directed, then random against tool arithmetic).

## Interface
- `TAM`, default 4: operand width in bits; minimum 2.
- `clk`  in  1: single clock; all state changes on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request; sampled only in IDLE.
- `A`  in  TAM: signed dividend; captured on the accepting edge.
- `B`  in  TAM: signed divisor; captured on the accepting edge.
- `Q`  out  TAM: signed quotient; registered, held until next `done`.
- `R`  out  TAM: signed remainder; registered, held until next `done`.
- `busy`  out  1: high from the cycle after acceptance until `done`, inclusive.
- `done`  out  1: one-cycle pulse; `Q`/`R`/flags are valid from this cycle on.
- `div_zero`  out  1: sticky with result; set when `B == 0`.
- `ovf`  out  1: sticky with result; set for most-negative ÷ −1.

## Operation
- States: IDLE, CALC, FIX.
- IDLE + `start`: latch `sa = A[TAM-1]`, `sb = B[TAM-1]`, `|A|`, `|B|` as TAM-bit unsigned values. `|most-negative|` = `2^(TAM-1)`, which fits unsigned.
- Clear the step counter and go to CALC.
- If `B == 0`, go straight to FIX with the zero flag set.
- CALC: one restoring step per cycle, exactly TAM cycles.
  - Shift the partial remainder (TAM+1 bits) and dividend left.
  - Trial-subtract `|B|`. If the result is non-negative, keep it and set the quotient bit; otherwise restore.
- FIX: register the outputs, then return to IDLE.
  - `Q = (sa ^ sb) ? −q : q`, truncated to TAM bits.
  - `R = sa ? −r : r`.
  - Pulse `done`.
- Divide by zero: `Q = all ones`, `R = A`, `div_zero = 1`, `ovf = 0`.
- Overflow (`A = −2^(TAM-1)`, `B = −1`): `Q = −2^(TAM-1)` (wraps), `R = 0`, `ovf = 1`.
- Every other case leaves `div_zero = ovf = 0`.
- `start` while busy is ignored; nothing is queued.

## Timing
- Reset value of every output (`Q`, `R`, `busy`, `done`, `div_zero`, `ovf`) is 0. State returns to IDLE.
- `rst` mid-operation aborts the division with no `done`. It has priority over `start` in the same cycle.
- Nonzero divisor, accepted at edge k:
  - `busy` is high from after edge k.
  - CALC occupies edges k+1 … k+TAM.
  - FIX registers the results at edge k+TAM+1, so `done = 1` during the cycle after that edge.
  - Latency is TAM+1 cycles from the accepting edge to `done`.
- Zero divisor: FIX at edge k+1, so `done` appears in the cycle after edge k+1.
- `busy` and `done` fall together on the edge after the `done` cycle.
- A new `start` may be accepted on the same edge at which `done` falls, giving back-to-back throughput of one result per TAM+2 cycles.
- `Q`, `R` and the flags change only at FIX.

## Structure
- Package `div_pkg`:
  - state enum localparams `S_IDLE`, `S_CALC`, `S_FIX`;
  - counter width function `clog2(TAM+1)`.
- Sub-module `div_step`: combinational single restoring step.
  - Inputs: partial remainder, next dividend bit, `|B|`.
  - Outputs: new remainder and quotient bit.
- The top module contains the FSM, counter, operand registers and sign fix.

## Test plan
- TAM=4, A=7, B=2 → `done` 5 cycles after the accepting edge, Q=3, R=1, flags 0.
- A=−7 (4'b1001), B=2 → Q=4'b1101 (−3), R=4'b1111 (−1). Then A=7, B=−2 → Q=−3, R=1.
- A=7, B=0 → `done` 1 cycle after acceptance, Q=4'hF, R=7, `div_zero=1`.
- A=−8, B=−1 → Q=4'b1000, R=0, `ovf=1`. A=−8, B=1 → Q=−8, R=0, `ovf=0`.
- `start` with A=5, B=3 pulsed during CALC of 7/2 → ignored, result stays 3/1. Assert `rst` at CALC cycle 2 → no `done`, all outputs 0 next cycle.
- 200 random operand pairs (B≠0, skipping the overflow case) → Q and R match tool signed `/` and `%`. `done` spacing is exactly TAM+2 cycles back to back.
